spi_rr_master: RTL and testbench

- Round-robin SPI master controller that shares one SPI bus (sclk, mosi, miso) between NUM_REQ requesters.
- Each requester has its own active-low chip select.
- Arbitrates pending requests, latches the winner's byte, and runs a full mode-0 (CPOL=0, CPHA=0), MSB-first transfer.
- Returns the captured miso byte and pulses done to the winner. Sits between the SPI pins and the on-chip clients that talk to SPI peripherals.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_rr_arbiter.sv | 33 +++
 rtl/spi_rr_master.sv | 192 +++++++++++++++++++
 tb/tb_spi_rr_master.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type and parameter defaults for the round-robin SPI master
package spi_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_XFER,
        S_STOP
    } spi_state_t;

    localparam int SPI_DATA_W  = 8;
    localparam int SPI_CLK_DIV = 4;

endpackage

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - combinational rotate-priority arbiter
//   req    : per-requester request vector
//   last   : index of the previous winner; the search starts at last+1
//   winner : one-hot grant candidate (zero when no request)
//   valid  : at least one request is pending
module spi_rr_arbiter
    import spi_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    // Outer loop walks priority order last+1, last+2, ...; inner loop maps
    // that position back to a requester index so every index stays constant.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!valid && req[i] && (((int'(last) + off) % NUM_REQ) == i)) begin
                    winner[i] = 1'b1;
                    valid     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_rr_master.sv
// rtl/spi_rr_master.sv - round-robin SPI mode-0 master shared by NUM_REQ requesters
//   clk, rst : system clock, synchronous active-high reset
//   req      : per-requester transfer request (level)
//   tx_data  : flat tx bytes, requester i at [i*DATA_W +: DATA_W], sampled at grant
//   gnt      : one-hot grant held for the whole transaction
//   done     : one-cycle pulse to the winner at the end of the transaction
//   rx_data  : captured byte, valid from done until the next done
//   busy     : controller not idle
//   sclk, cs_n, mosi, miso : SPI pins (sclk idles low, cs_n active low)
//   SPI_LOOPBACK_EN : when defined, bits are sampled from mosi instead of miso
module spi_rr_master
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] tx_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      busy,
    output logic                      sclk,
    output logic [NUM_REQ-1:0]        cs_n,
    output logic                      mosi,
    input  logic                      miso
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

    spi_state_t         state, nxt_state;
    logic [DIV_W-1:0]   div_cnt, nxt_div;
    logic [BIT_W-1:0]   bit_cnt, nxt_bit;
    logic [DATA_W-1:0]  tx_sr, nxt_tx_sr;
    logic [DATA_W-1:0]  rx_sr, nxt_rx_sr;
    logic [PTR_W-1:0]   last, nxt_last;

    logic [NUM_REQ-1:0] nxt_gnt, nxt_done, nxt_cs_n;
    logic [DATA_W-1:0]  nxt_rx_data;
    logic               nxt_busy, nxt_sclk, nxt_mosi;

    logic [NUM_REQ-1:0] arb_winner;
    logic               arb_valid;
    logic               div_end;
    logic               sample_bit;

`ifdef SPI_LOOPBACK_EN
    assign sample_bit = mosi;
`else
    assign sample_bit = miso;
`endif

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .req    (req),
        .last   (last),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    assign div_end = (div_cnt == DIV_LAST);

    always_comb begin
        nxt_state   = state;
        nxt_div     = div_cnt;
        nxt_bit     = bit_cnt;
        nxt_tx_sr   = tx_sr;
        nxt_rx_sr   = rx_sr;
        nxt_last    = last;
        nxt_gnt     = gnt;
        nxt_done    = '0;
        nxt_rx_data = rx_data;
        nxt_sclk    = sclk;
        nxt_cs_n    = cs_n;
        nxt_mosi    = mosi;

        case (state)
            S_IDLE: begin
                if (arb_valid) begin
                    nxt_state = S_START;
                    nxt_div   = '0;
                    nxt_bit   = '0;
                    nxt_gnt   = arb_winner;
                    nxt_cs_n  = ~arb_winner;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_winner[i]) begin
                            nxt_last  = PTR_W'(i);
                            nxt_tx_sr = tx_data[i*DATA_W +: DATA_W];
                        end
                    end
                    nxt_mosi = nxt_tx_sr[DATA_W-1];
                end
            end

            S_START: begin
                if (div_end) begin
                    // Setup half done: first rising sclk edge samples bit 0.
                    nxt_state = S_XFER;
                    nxt_div   = '0;
                    nxt_bit   = '0;
                    nxt_sclk  = 1'b1;
                    nxt_rx_sr = DATA_W'({rx_sr, sample_bit});
                end else begin
                    nxt_div = div_cnt + 1'b1;
                end
            end

            S_XFER: begin
                if (!div_end) begin
                    nxt_div = div_cnt + 1'b1;
                end else begin
                    nxt_div = '0;
                    if (sclk) begin
                        // Falling edge: present the next bit.
                        nxt_sclk  = 1'b0;
                        nxt_tx_sr = {tx_sr[DATA_W-2:0], 1'b0};
                        nxt_mosi  = tx_sr[DATA_W-2];
                    end else if (bit_cnt == BIT_LAST) begin
                        nxt_state = S_STOP;
                        nxt_bit   = '0;
                        nxt_mosi  = 1'b0;
                    end else begin
                        // Rising edge: capture the next incoming bit.
                        nxt_sclk  = 1'b1;
                        nxt_bit   = bit_cnt + 1'b1;
                        nxt_rx_sr = DATA_W'({rx_sr, sample_bit});
                    end
                end
            end

            S_STOP: begin
                if (div_end) begin
                    nxt_state   = S_IDLE;
                    nxt_div     = '0;
                    nxt_cs_n    = '1;
                    nxt_gnt     = '0;
                    nxt_done    = gnt;
                    nxt_rx_data = rx_sr;
                end else begin
                    nxt_div = div_cnt + 1'b1;
                end
            end

            default: nxt_state = S_IDLE;
        endcase

        nxt_busy = (nxt_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            last    <= PTR_INIT;
            gnt     <= '0;
            done    <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
            sclk    <= 1'b0;
            cs_n    <= '1;
            mosi    <= 1'b0;
        end else begin
            state   <= nxt_state;
            div_cnt <= nxt_div;
            bit_cnt <= nxt_bit;
            tx_sr   <= nxt_tx_sr;
            rx_sr   <= nxt_rx_sr;
            last    <= nxt_last;
            gnt     <= nxt_gnt;
            done    <= nxt_done;
            rx_data <= nxt_rx_data;
            busy    <= nxt_busy;
            sclk    <= nxt_sclk;
            cs_n    <= nxt_cs_n;
            mosi    <= nxt_mosi;
        end
    end

endmodule

// File: tb/tb_spi_rr_master.sv
// tb/tb_spi_rr_master.sv - self-checking bench for spi_rr_master
module tb_spi_rr_master;

    localparam int NUM_REQ    = 4;
    localparam int DATA_W     = 8;
    localparam int CLK_DIV    = 4;
    localparam int CS_LEN     = (2*DATA_W + 2) * CLK_DIV;
    localparam int TXN_BUDGET = 2*CS_LEN + 20;
`ifdef SPI_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] tx_data = '0;
    logic        miso = 1'b0;
    logic [3:0]  gnt, done, cs_n;
    logic [7:0]  rx_data;
    logic        busy, sclk, mosi;

    spi_rr_master #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .tx_data (tx_data),
        .gnt     (gnt),
        .done    (done),
        .rx_data (rx_data),
        .busy    (busy),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int model_last = NUM_REQ - 1;

    typedef struct {
        logic [3:0] done_vec;
        logic [3:0] sel;
        logic [7:0] rx;
        logic [7:0] mosi_b;
        logic [7:0] slave;
        int         len;
        int         rises;
        int         bad;
        int         gap;
    } rec_t;

    rec_t recq[$];
    rec_t cur;
    bit   in_txn = 0;
    int   run_len = 0;
    int   gap = 0;
    logic prev_sclk = 1'b0;
    int   done_cycles = 0, gnt_cs_bad = 0, multi_cs = 0, idle_bad = 0;
    bit   slave_rand = 1;
    logic [7:0] slave_next = '0;

    // Bus monitor and SPI slave: measures each chip-select window, checks
    // sclk half-periods, shifts mosi in on rising sclk and drives miso.
    always @(negedge clk) begin
        if (rst) begin
            in_txn = 0; run_len = 0; gap = 0; prev_sclk = 1'b0; miso = 1'b0;
        end else begin
            if (done != '0) done_cycles++;
            if (gnt !== ~cs_n) gnt_cs_bad++;
            if ($countones(~cs_n) > 1) multi_cs++;
            if (cs_n != 4'hF) begin
                if (!in_txn) begin
                    in_txn = 1;
                    cur.sel = ~cs_n; cur.len = 0; cur.rises = 0; cur.bad = 0;
                    cur.mosi_b = '0; cur.gap = gap; cur.done_vec = '0; cur.rx = '0;
                    cur.slave = slave_rand ? 8'($urandom) : slave_next;
                    run_len = 0; prev_sclk = 1'b0;
                end else if (~cs_n != cur.sel) begin
                    cur.bad++;
                end
                cur.len++;
                if (sclk == prev_sclk) begin
                    run_len++;
                end else begin
                    if (run_len != CLK_DIV) cur.bad++;
                    if (sclk) begin
                        cur.rises++;
                        cur.mosi_b = {cur.mosi_b[6:0], mosi};
                    end
                    run_len = 1;
                end
                prev_sclk = sclk;
                miso = (cur.rises < DATA_W) ? cur.slave[DATA_W-1-cur.rises] : 1'b0;
            end else begin
                if (in_txn) begin
                    // last low half plus the stop phase form one low run
                    if (prev_sclk || run_len != 2*CLK_DIV) cur.bad++;
                    cur.done_vec = done;
                    cur.rx = rx_data;
                    recq.push_back(cur);
                    in_txn = 0; gap = 0;
                end
                if (sclk || mosi) idle_bad++;
                gap++;
                miso = 1'b0;
            end
        end
    end

    function automatic int model_pick(input logic [3:0] r, input int lst);
        for (int k = 1; k <= NUM_REQ; k++)
            if (r[(lst + k) % NUM_REQ]) return (lst + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [7:0] exp_rx(input logic [7:0] tx_b, input logic [7:0] slave_b);
        return LOOPBACK ? tx_b : slave_b;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        repeat (3) step();
        recq.delete();
        done_cycles = 0; gnt_cs_bad = 0; multi_cs = 0; idle_bad = 0;
        model_last = NUM_REQ - 1;
        slave_rand = 1;
        rst = 1'b0;
    endtask

    task automatic wait_recs(input int n, input int budget, input string name);
        int c = 0;
        while (recq.size() < n && c < budget) begin
            step();
            c++;
        end
        checks++;
        if (recq.size() < n) begin
            errors++;
            $display("FAIL %s: timeout, records=%0d required=%0d", name, recq.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt !== 4'h0)    begin errors++; $display("FAIL reset_gnt: got %h required 0", gnt); end
        checks++; if (done !== 4'h0)   begin errors++; $display("FAIL reset_done: got %h required 0", done); end
        checks++; if (rx_data !== 8'h0) begin errors++; $display("FAIL reset_rx_data: got %h required 00", rx_data); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (sclk !== 1'b0)   begin errors++; $display("FAIL reset_sclk: got %b required 0", sclk); end
        checks++; if (cs_n !== 4'hF)   begin errors++; $display("FAIL reset_cs_n: got %h required f", cs_n); end
        checks++; if (mosi !== 1'b0)   begin errors++; $display("FAIL reset_mosi: got %b required 0", mosi); end
        repeat (5) step();
        checks++; if (busy !== 1'b0 || recq.size() != 0)
            begin errors++; $display("FAIL idle_quiet: busy=%b records=%0d required 0/0", busy, recq.size()); end
    endtask

    task automatic test_single();
        rec_t r;
        int   w;
        do_reset();
        slave_rand = 0; slave_next = 8'hA5;
        tx_data = $urandom;
        tx_data[7:0] = 8'hEF;
        req = 4'b0001;
        step();
        checks++; if (gnt !== 4'b0001)  begin errors++; $display("FAIL single_gnt_latency: got %b required 0001", gnt); end
        checks++; if (cs_n !== 4'b1110) begin errors++; $display("FAIL single_cs_n: got %b required 1110", cs_n); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL single_busy: got %b required 1", busy); end
        checks++; if (mosi !== 1'b1)    begin errors++; $display("FAIL single_mosi_msb: got %b required 1", mosi); end
        req = '0;
        w = model_pick(4'b0001, model_last); model_last = w;
        wait_recs(1, TXN_BUDGET, "single_wait");
        if (recq.size() > 0) begin
            r = recq.pop_front();
            checks++; if (r.done_vec !== 4'(1 << w)) begin errors++; $display("FAIL single_done: got %b required %b", r.done_vec, 4'(1 << w)); end
            checks++; if (r.mosi_b !== 8'hEF) begin errors++; $display("FAIL single_mosi_bits: got %h required ef", r.mosi_b); end
            checks++; if (r.rx !== exp_rx(8'hEF, 8'hA5)) begin errors++; $display("FAIL single_rx: got %h required %h", r.rx, exp_rx(8'hEF, 8'hA5)); end
            checks++; if (r.len != CS_LEN) begin errors++; $display("FAIL single_cs_len: got %0d required %0d", r.len, CS_LEN); end
            checks++; if (r.rises != DATA_W || r.bad != 0)
                begin errors++; $display("FAIL single_sclk_shape: pulses=%0d bad_runs=%0d required %0d/0", r.rises, r.bad, DATA_W); end
            step();
            checks++; if (done !== 4'h0 || rx_data !== exp_rx(8'hEF, 8'hA5))
                begin errors++; $display("FAIL single_done_width: done=%b rx=%h required 0000/%h", done, rx_data, exp_rx(8'hEF, 8'hA5)); end
        end
    endtask

    task automatic test_held_requests(input logic [3:0] pat, input int n);
        rec_t       r;
        int         w;
        logic [3:0] exp_sel;
        do_reset();
        tx_data = $urandom;
        req = pat;
        for (int k = 0; k < n; k++) begin
            wait_recs(1, TXN_BUDGET, "held_wait");
            if (recq.size() == 0) break;
            if (k == n - 1) req = '0;
            r = recq.pop_front();
            w = model_pick(pat, model_last); model_last = w;
            exp_sel = 4'(1 << w);
            checks++; if (r.done_vec !== exp_sel || r.sel !== exp_sel)
                begin errors++; $display("FAIL held_order[%0d] pat=%b: done=%b cs=%b required %b", k, pat, r.done_vec, r.sel, exp_sel); end
            checks++; if (r.mosi_b !== tx_data[w*8 +: 8])
                begin errors++; $display("FAIL held_mosi[%0d]: got %h required %h", k, r.mosi_b, tx_data[w*8 +: 8]); end
            checks++; if (r.rx !== exp_rx(tx_data[w*8 +: 8], r.slave))
                begin errors++; $display("FAIL held_rx[%0d]: got %h required %h", k, r.rx, exp_rx(tx_data[w*8 +: 8], r.slave)); end
            checks++; if (r.len != CS_LEN || r.rises != DATA_W || r.bad != 0)
                begin errors++; $display("FAIL held_shape[%0d]: len=%0d pulses=%0d bad=%0d", k, r.len, r.rises, r.bad); end
            if (k > 0) begin
                checks++; if (r.gap != 1) begin errors++; $display("FAIL held_gap[%0d]: got %0d required 1", k, r.gap); end
            end
        end
        repeat (4) step();
        checks++; if (busy !== 1'b0 || recq.size() != 0)
            begin errors++; $display("FAIL held_end_idle: busy=%b records=%0d required 0/0", busy, recq.size()); end
        checks++; if (multi_cs != 0 || gnt_cs_bad != 0 || idle_bad != 0)
            begin errors++; $display("FAIL held_bus_rules: multi_cs=%0d gnt_cs=%0d idle=%0d required 0", multi_cs, gnt_cs_bad, idle_bad); end
        checks++; if (done_cycles != n) begin errors++; $display("FAIL held_done_count: got %0d required %0d", done_cycles, n); end
    endtask

    task automatic test_req_drop();
        rec_t       r;
        logic [7:0] orig;
        do_reset();
        tx_data = $urandom;
        orig = tx_data[15:8];
        req = 4'b0010;
        step();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL drop_gnt: got %b required 0010", gnt); end
        repeat (10) step();
        req = '0;
        tx_data[15:8] = ~orig;
        wait_recs(1, TXN_BUDGET, "drop_wait");
        if (recq.size() > 0) begin
            r = recq.pop_front();
            checks++; if (r.done_vec !== 4'b0010) begin errors++; $display("FAIL drop_done: got %b required 0010", r.done_vec); end
            checks++; if (r.mosi_b !== orig) begin errors++; $display("FAIL drop_tx_sampled_at_grant: got %h required %h", r.mosi_b, orig); end
            checks++; if (r.len != CS_LEN) begin errors++; $display("FAIL drop_cs_len: got %0d required %0d", r.len, CS_LEN); end
        end
        repeat (20) step();
        checks++; if (recq.size() != 0 || busy !== 1'b0 || gnt !== 4'h0)
            begin errors++; $display("FAIL drop_no_regrant: records=%0d busy=%b gnt=%b required 0/0/0000", recq.size(), busy, gnt); end
    endtask

    task automatic test_reset_mid();
        rec_t r;
        int   c = 0;
        do_reset();
        tx_data = $urandom;
        req = 4'b0001;
        while (!(in_txn && cur.rises == 4) && c < TXN_BUDGET) begin
            step();
            c++;
        end
        req = '0;
        checks++; if (!(in_txn && cur.rises == 4))
            begin errors++; $display("FAIL rmid_reach_bit3: pulses=%0d required 4", cur.rises); end
        rst = 1'b1;
        step();
        checks++; if (cs_n !== 4'hF || sclk !== 1'b0 || mosi !== 1'b0)
            begin errors++; $display("FAIL rmid_pins: cs_n=%h sclk=%b mosi=%b required f/0/0", cs_n, sclk, mosi); end
        checks++; if (gnt !== 4'h0 || busy !== 1'b0 || done !== 4'h0)
            begin errors++; $display("FAIL rmid_ctrl: gnt=%b busy=%b done=%b required 0000/0/0000", gnt, busy, done); end
        rst = 1'b0;
        model_last = NUM_REQ - 1;
        req = 4'b0011;
        step();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_pointer_reset: got %b required 0001", gnt); end
        checks++; if (recq.size() != 0 || done_cycles != 0)
            begin errors++; $display("FAIL rmid_no_done: records=%0d done_cycles=%0d required 0", recq.size(), done_cycles); end
        req = '0;
        model_last = model_pick(4'b0011, model_last);
        wait_recs(1, TXN_BUDGET, "rmid_wait");
        if (recq.size() > 0) begin
            r = recq.pop_front();
            checks++; if (r.done_vec !== 4'(1 << model_last) || r.mosi_b !== tx_data[7:0])
                begin errors++; $display("FAIL rmid_followup: done=%b mosi=%h required %b/%h", r.done_vec, r.mosi_b, 4'(1 << model_last), tx_data[7:0]); end
        end
    endtask

    task automatic test_loopback();
        rec_t r;
        do_reset();
        slave_rand = 0; slave_next = 8'h00;
        tx_data = $urandom;
        tx_data[31:24] = 8'h3C;
        req = 4'b1000;
        step();
        req = '0;
        wait_recs(1, TXN_BUDGET, "loop_wait");
        if (recq.size() > 0) begin
            r = recq.pop_front();
            checks++; if (r.done_vec !== 4'b1000) begin errors++; $display("FAIL loop_done: got %b required 1000", r.done_vec); end
            checks++; if (r.rx !== exp_rx(8'h3C, 8'h00))
                begin errors++; $display("FAIL loop_rx: got %h required %h", r.rx, exp_rx(8'h3C, 8'h00)); end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_held_requests(4'b0101, 4);
        test_held_requests(4'b1111, 5);
        test_held_requests(4'($urandom_range(1, 15)), 6);
        test_req_drop();
        test_reset_mid();
        test_loopback();
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
